// File: rtl/approx_err_monitor.sv
// Response-side checker for an 8-bit approximate adder: per-sample exact sum and error
// distance, windowed error statistics, and a held report handed out via valid/ready.
module approx_err_monitor #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [8:0]       approx_sum,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_err_cnt,
    output logic [CNT_W-1:0] rpt_cout_err_cnt,
    output logic [SUM_W-1:0] rpt_ed_sum,
    output logic [8:0]       rpt_ed_max,
    output logic             busy
);
    typedef enum logic {ST_ACCUM = 1'b0, ST_REPORT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    // One spare bit above the wider of the accumulator and ED so the add can't wrap
    localparam int               EXT_W    = ((SUM_W > 9) ? SUM_W : 9) + 1;
    localparam logic [EXT_W-1:0] SUM_MAX  = (EXT_W'(1) << SUM_W) - EXT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_upd_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_cout_err_cnt;
    logic [SUM_W-1:0] r_ed_sum;
    logic [SUM_W-1:0] w_ed_sum_next;
    logic [8:0]       r_ed_max;
    logic             r_s1_valid;
    logic [8:0]       r_s1_ed;
    logic             r_s1_cout_mis;
    logic [8:0]       w_exact;
    logic [8:0]       w_ed;
    logic             w_cout_mis;
    logic             w_accept;
    logic             w_last_upd;
    logic             w_rpt_take;
    logic [EXT_W-1:0] w_sum_ext;

    assign in_ready   = (r_state == ST_ACCUM) && (r_acc_cnt < WIN_CNT) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_last_upd = r_s1_valid && (r_upd_cnt == WIN_LAST);
    assign w_rpt_take = (r_state == ST_REPORT) && rpt_ready;

    always_comb begin
        w_exact    = {1'b0, a} + {1'b0, b};
        w_ed       = (w_exact >= approx_sum) ? (w_exact - approx_sum) : (approx_sum - w_exact);
        w_cout_mis = w_exact[8] ^ approx_sum[8];
    end

    always_comb begin
        w_sum_ext     = EXT_W'(r_ed_sum) + EXT_W'(r_s1_ed);
        w_ed_sum_next = (w_sum_ext > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : w_sum_ext[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM:  if (w_last_upd) w_state_next = ST_REPORT;
            ST_REPORT: if (rpt_ready)  w_state_next = ST_ACCUM;
        endcase
    end

    // Stage S1: exact sum, error distance and carry-out mismatch per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_ed       <= '0;
            r_s1_cout_mis <= 1'b0;
        end else begin
            r_s1_valid    <= w_accept;
            r_s1_ed       <= w_ed;
            r_s1_cout_mis <= w_cout_mis;
        end
    end

    // Stage S2: window accumulators, which double as the report registers
    always_ff @(posedge clk) begin
        if (rst || w_rpt_take) begin
            r_acc_cnt      <= '0;
            r_upd_cnt      <= '0;
            r_err_cnt      <= '0;
            r_cout_err_cnt <= '0;
            r_ed_sum       <= '0;
            r_ed_max       <= '0;
        end else begin
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (r_s1_valid) begin
                r_upd_cnt      <= r_upd_cnt + CNT_W'(1);
                r_err_cnt      <= r_err_cnt + CNT_W'(r_s1_ed != '0);
                r_cout_err_cnt <= r_cout_err_cnt + CNT_W'(r_s1_cout_mis);
                r_ed_sum       <= w_ed_sum_next;
                if (r_s1_ed > r_ed_max) begin
                    r_ed_max <= r_s1_ed;
                end
            end
        end
    end

    assign rpt_valid        = (r_state == ST_REPORT);
    assign rpt_err_cnt      = r_err_cnt;
    assign rpt_cout_err_cnt = r_cout_err_cnt;
    assign rpt_ed_sum       = r_ed_sum;
    assign rpt_ed_max       = r_ed_max;
    assign busy             = (r_acc_cnt != '0) || r_s1_valid || (r_state == ST_REPORT);

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: four instances with different windows/widths, a sample
// list model per instance, and a report scoreboard popped on each report handshake.
module tb_approx_err_monitor;
    localparam int NI = 4;

    function automatic int win_of(input int k);
        case (k)
            0:       return 1;
            1:       return 5;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int sw_of(input int k);
        return (k == 2) ? 9 : 24;
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] p;
    } sample_t;

    typedef struct {
        longint err;
        longint cerr;
        longint sum;
        longint max;
    } rpt_t;

    logic        clk = 1'b0;
    logic        rst[NI];
    logic        in_valid[NI];
    logic        in_ready[NI];
    logic [7:0]  a[NI];
    logic [7:0]  b[NI];
    logic [8:0]  ap[NI];
    logic        rpt_valid[NI];
    logic        rpt_ready[NI];
    logic [15:0] err_cnt[NI];
    logic [15:0] cerr_cnt[NI];
    logic [23:0] ed_sum[NI];
    logic [8:0]  ed_max[NI];
    logic        busy[NI];

    sample_t sm[NI][$];
    rpt_t    exp_q[NI][$];
    int      n_checks = 0;
    int      n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int SW = sw_of(gi);
        logic [SW-1:0] w_sum;
        approx_err_monitor #(.WINDOW(win_of(gi)), .CNT_W(16), .SUM_W(SW)) u_dut (
            .clk              (clk),
            .rst              (rst[gi]),
            .in_valid         (in_valid[gi]),
            .in_ready         (in_ready[gi]),
            .a                (a[gi]),
            .b                (b[gi]),
            .approx_sum       (ap[gi]),
            .rpt_valid        (rpt_valid[gi]),
            .rpt_ready        (rpt_ready[gi]),
            .rpt_err_cnt      (err_cnt[gi]),
            .rpt_cout_err_cnt (cerr_cnt[gi]),
            .rpt_ed_sum       (w_sum),
            .rpt_ed_max       (ed_max[gi]),
            .busy             (busy[gi])
        );
        assign ed_sum[gi] = 24'(w_sum);
    end

    task automatic chk(input string name, input int k, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s inst=%0d got=%0d expected=%0d", name, k, got, exp);
    endtask

    // Reference: report derived from the plain list of samples accepted in the window
    function automatic rpt_t model_report(input int k);
        rpt_t r;
        int   ex;
        int   p;
        int   ed;
        r = '{err: 0, cerr: 0, sum: 0, max: 0};
        for (int i = 0; i < sm[k].size(); i++) begin
            ex = int'(sm[k][i].a) + int'(sm[k][i].b);
            p  = int'(sm[k][i].p);
            ed = (ex > p) ? ex - p : p - ex;
            if (ed != 0) r.err++;
            if ((ex >= 256) != (p >= 256)) r.cerr++;
            r.sum += ed;
            if (ed > r.max) r.max = ed;
        end
        if (r.sum > (longint'(1) << sw_of(k)) - 1) r.sum = (longint'(1) << sw_of(k)) - 1;
        return r;
    endfunction

    function automatic logic [8:0] rand_ap(input logic [7:0] av, input logic [7:0] bv);
        logic [8:0] ex;
        ex = {1'b0, av} + {1'b0, bv};
        if ($urandom_range(0, 1) == 0) return ex;
        return ex ^ 9'($urandom_range(1, 511));
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic [8:0] pv, input int gap);
        int      t;
        bit      ok;
        sample_t s;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        a[k] = av; b[k] = bv; ap[k] = pv; in_valid[k] = 1'b1;
        t = 0; ok = 1'b0;
        while (!ok && t < 300) begin
            @(negedge clk);
            if (in_ready[k]) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            chk("accept_timeout", k, longint'(in_ready[k]), 1);
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        s.a = av; s.b = bv; s.p = pv;
        sm[k].push_back(s);
        $display("accept inst=%0d a=%02h b=%02h approx=%03h", k, av, bv, pv);
        if (sm[k].size() == win_of(k)) begin
            exp_q[k].push_back(model_report(k));
            sm[k].delete();
        end
    endtask

    task automatic send_rand(input int k, input int n, input int max_gap);
        logic [7:0] av;
        logic [7:0] bv;
        for (int i = 0; i < n; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            send(k, av, bv, rand_ap(av, bv), $urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_report(input int k);
        int t;
        t = 0;
        while (!rpt_valid[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("report_arrives", k, longint'(rpt_valid[k]), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rpt_t r;
        int   edsum_drv;
        int   ex;
        int   t;
        bit   pending;
        logic [7:0] av;
        logic [7:0] bv;
        logic [8:0] pv;

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; rpt_ready[k] = 1'b1;
            a[k] = '0; b[k] = '0; ap[k] = '0;
        end

        // Scoreboard monitor: compares the report on every report handshake
        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < NI; k++) begin
                    if (rpt_valid[k] && rpt_ready[k]) begin
                        $display("report inst=%0d err=%0d cout_err=%0d ed_sum=%0d ed_max=%0d",
                                 k, err_cnt[k], cerr_cnt[k], ed_sum[k], ed_max[k]);
                        if (exp_q[k].size() == 0) begin
                            chk("unexpected_report", k, 1, 0);
                        end else begin
                            r = exp_q[k].pop_front();
                            chk("sb_err_cnt", k, longint'(err_cnt[k]), r.err);
                            chk("sb_cout_err_cnt", k, longint'(cerr_cnt[k]), r.cerr);
                            chk("sb_ed_sum", k, longint'(ed_sum[k]), r.sum);
                            chk("sb_ed_max", k, longint'(ed_max[k]), r.max);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_in_ready", k, longint'(in_ready[k]), 0);
            chk("rst_rpt_valid", k, longint'(rpt_valid[k]), 0);
            chk("rst_busy", k, longint'(busy[k]), 0);
            chk("rst_ed_sum", k, longint'(ed_sum[k]), 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk("post_rst_in_ready", k, longint'(in_ready[k]), 1);
        @(posedge clk);
        #1;

        // WINDOW=1, exact adder: report two cycles after acceptance
        rpt_ready[0] = 1'b0;
        send(0, 8'hED, 8'h6D, 9'h15A, 0);
        @(negedge clk);
        chk("w1_valid_s1", 0, longint'(rpt_valid[0]), 0);
        @(negedge clk);
        chk("w1_valid_s2", 0, longint'(rpt_valid[0]), 1);
        chk("w1_err_cnt", 0, longint'(err_cnt[0]), 0);
        chk("w1_cout_err", 0, longint'(cerr_cnt[0]), 0);
        chk("w1_ed_sum", 0, longint'(ed_sum[0]), 0);
        chk("w1_ed_max", 0, longint'(ed_max[0]), 0);
        @(posedge clk);
        #1;
        rpt_ready[0] = 1'b1;
        send_rand(0, 12, 2);

        // WINDOW=5 known vectors, then report back-pressure with a held sample
        rpt_ready[1] = 1'b0;
        send(1, 8'hED, 8'h6D, 9'h158, 0);
        send(1, 8'hDE, 8'hC2, 9'h1A0, 0);
        send(1, 8'hDE, 8'hD8, 9'h1B0, 0);
        send(1, 8'hE8, 8'hB3, 9'h19B, 0);
        send(1, 8'hB9, 8'hED, 9'h0A6, 0);
        wait_report(1);
        chk("w5_err_cnt", 1, longint'(err_cnt[1]), 3);
        chk("w5_cout_err", 1, longint'(cerr_cnt[1]), 1);
        chk("w5_ed_sum", 1, longint'(ed_sum[1]), 264);
        chk("w5_ed_max", 1, longint'(ed_max[1]), 256);
        av = 8'($urandom); bv = 8'($urandom); pv = rand_ap(av, bv);
        fork
            send(1, av, bv, pv, 0);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 1, longint'(in_ready[1]), 0);
                    chk("bp_rpt_valid", 1, longint'(rpt_valid[1]), 1);
                    chk("bp_ed_sum_hold", 1, longint'(ed_sum[1]), 264);
                    chk("bp_ed_max_hold", 1, longint'(ed_max[1]), 256);
                end
                @(posedge clk);
                #1;
                rpt_ready[1] = 1'b1;
                @(posedge clk);
                #1;
                rpt_ready[1] = 1'b0;
                @(negedge clk);
                chk("bp_release_valid", 1, longint'(rpt_valid[1]), 0);
                chk("bp_release_ready", 1, longint'(in_ready[1]), 1);
            end
        join
        rpt_ready[1] = 1'b1;
        send_rand(1, 4, 1);
        send_rand(1, 10, 2);

        // Reset mid-window on the WINDOW=5 instance
        for (int i = 0; i < 3; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            ex = int'(av) + int'(bv);
            send(1, av, bv, 9'(ex + 1), 0);
        end
        rst[1] = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 1, longint'(in_ready[1]), 0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        sm[1].delete();
        exp_q[1].delete();
        @(negedge clk);
        chk("mid_rst_busy", 1, longint'(busy[1]), 0);
        chk("mid_rst_rpt_valid", 1, longint'(rpt_valid[1]), 0);
        chk("mid_rst_err_cnt", 1, longint'(err_cnt[1]), 0);
        chk("mid_rst_ed_sum", 1, longint'(ed_sum[1]), 0);
        chk("mid_rst_ed_max", 1, longint'(ed_max[1]), 0);
        @(posedge clk);
        #1;
        rpt_ready[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            send(1, av, bv, {1'b0, av} + {1'b0, bv}, 0);
        end
        wait_report(1);
        chk("post_rst_err_cnt", 1, longint'(err_cnt[1]), 0);
        rpt_ready[1] = 1'b1;

        // Saturating accumulator: SUM_W=9, four samples of ED=510
        rpt_ready[2] = 1'b0;
        for (int i = 0; i < 4; i++) send(2, 8'hFF, 8'hFF, 9'h000, 0);
        wait_report(2);
        chk("sat_ed_sum", 2, longint'(ed_sum[2]), 511);
        chk("sat_ed_max", 2, longint'(ed_max[2]), 510);
        chk("sat_err_cnt", 2, longint'(err_cnt[2]), 4);
        chk("sat_cout_err", 2, longint'(cerr_cnt[2]), 4);
        rpt_ready[2] = 1'b1;
        send_rand(2, 8, 1);

        // Gapped input, WINDOW=8: driven ED total must match, no ninth acceptance
        rpt_ready[3] = 1'b0;
        edsum_drv = 0;
        for (int i = 0; i < 8; i++) begin
            av = 8'($urandom); bv = 8'($urandom); pv = rand_ap(av, bv);
            ex = int'(av) + int'(bv);
            edsum_drv += (ex > int'(pv)) ? ex - int'(pv) : int'(pv) - ex;
            send(3, av, bv, pv, $urandom_range(0, 3));
        end
        wait_report(3);
        chk("gap_ed_sum", 3, longint'(ed_sum[3]), longint'(edsum_drv));
        in_valid[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gap_full_in_ready", 3, longint'(in_ready[3]), 0);
        end
        @(posedge clk);
        #1;
        in_valid[3] = 1'b0;
        rpt_ready[3] = 1'b1;
        send_rand(3, 16, 3);

        // Drain outstanding reports, then everything must be idle
        t = 0;
        pending = 1'b1;
        while (pending && t < 200) begin
            @(posedge clk);
            t++;
            pending = 1'b0;
            for (int k = 0; k < NI; k++) if (exp_q[k].size() != 0) pending = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reports_outstanding", k, longint'(exp_q[k].size()), 0);
            chk("final_busy", k, longint'(busy[k]), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
